// File: rtl/sb_sim_pkg.sv
// Shared switchboard simulation types and in-memory queue access functions.
package sb_sim_pkg;

  localparam int unsigned SB_MAX_DW = 256;
  localparam int unsigned SB_DEST_W = 32;

  typedef struct packed {
    logic [SB_MAX_DW-1:0] data;
    logic [SB_DEST_W-1:0] dest;
    logic                 last;
  } sb_pkt_t;

  // Native stand-in: a small table of named packet queues, fed with sb_sim_send.
  localparam int unsigned SB_SIM_NQ = 8;
  localparam int unsigned SB_SIM_QW = 3;

  string   sb_sim_uri [SB_SIM_NQ];
  int      sb_sim_used;
  sb_pkt_t sb_sim_q   [SB_SIM_NQ][$];

  function automatic int sb_sim_lookup(input string uri);
    for (int i = 0; i < sb_sim_used; i++) begin
      if (sb_sim_uri[SB_SIM_QW'(i)] == uri) return i;
    end
    if (sb_sim_used >= int'(SB_SIM_NQ)) return -1;
    sb_sim_uri[SB_SIM_QW'(sb_sim_used)] = uri;
    sb_sim_used++;
    return sb_sim_used - 1;
  endfunction

  function automatic void pi_sb_rx_init(output int id, input string uri);
    id = sb_sim_lookup(uri);
  endfunction

  function automatic void pi_sb_recv(input int id, output logic [255:0] rdata,
                                     output logic [31:0] rdest, output logic rlast,
                                     output int success);
    sb_pkt_t pkt;
    pkt     = '0;
    success = 0;
    if (id >= 0 && id < sb_sim_used) begin
      if (sb_sim_q[SB_SIM_QW'(id)].size() > 0) begin
        pkt     = sb_sim_q[SB_SIM_QW'(id)].pop_front();
        success = 1;
      end
    end
    rdata = pkt.data;
    rdest = pkt.dest;
    rlast = pkt.last;
  endfunction

  function automatic void sb_sim_send(input string uri, input sb_pkt_t pkt);
    int id;
    id = sb_sim_lookup(uri);
    if (id >= 0) sb_sim_q[SB_SIM_QW'(id)].push_back(pkt);
  endfunction

endpackage

// File: rtl/sb_sim_fifo.sv
// Generic synchronous FIFO with combinational head read and explicit occupancy counter.
module sb_sim_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic [W-1:0]                 push_data_i,
  input  logic                         pop_i,
  output logic [W-1:0]                 head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push_c, do_pop_c;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_pop_c  = pop_i && !empty_o;
  assign do_push_c = push_i && (!full_o || do_pop_c);
  assign head_o    = mem_q[rptr_q];
  assign count_o   = count_q;

  always_comb begin
    count_d = count_q;
    case ({do_push_c, do_pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push_c) wptr_q <= wptr_q + AW'(1);
      if (do_pop_c)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage is not reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (do_push_c) mem_q[wptr_q] <= push_data_i;
  end

endmodule

// File: rtl/sb_rx_sim_buf.sv
// Switchboard receive endpoint: throttled queue polling into a prefetch FIFO, ready/valid out.
// A freshly polled packet lands in a stage register so it is visible right after the poll edge.
module sb_rx_sim_buf
  import sb_sim_pkg::*;
#(
  parameter int unsigned DW          = 256,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned POLL_PERIOD = 1
) (
  input  logic                        clk,
  input  logic                        nreset,
  input  logic                        en,
  output logic [DW-1:0]               data,
  output logic [SB_DEST_W-1:0]        dest,
  output logic                        last,
  output logic                        valid,
  input  logic                        ready,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic [31:0]                 pkt_cnt
);

  localparam int unsigned PKT_W = DW + SB_DEST_W + 1;
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam int unsigned PC_W  = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

  bit initialized;
  int sb_id;

  function automatic void init(input string uri);
    int id;
    pi_sb_rx_init(id, uri);
    sb_id       = id;
    initialized = 1'b1;
  endfunction

  logic [PKT_W-1:0] stage_q;
  logic             stage_vld_q;
  logic [PC_W-1:0]  poll_cnt_q, poll_cnt_d;
  logic [31:0]      pkt_cnt_q;

  logic [PKT_W-1:0] fifo_head, head_c;
  logic [CNT_W-1:0] fifo_count, occ_c;
  logic             fifo_full, fifo_empty;
  logic             poll_c, pop_c, fifo_pop_c, fifo_push_c;

  assign occ_c       = fifo_count + CNT_W'(stage_vld_q);
  assign poll_c      = en && initialized && (occ_c < CNT_W'(DEPTH)) && (poll_cnt_q == '0);
  assign valid       = !fifo_empty || stage_vld_q;
  assign pop_c       = valid && ready;
  assign fifo_pop_c  = pop_c && !fifo_empty;
  // The staged packet is consumed directly when it is the head; otherwise it joins the FIFO.
  assign fifo_push_c = stage_vld_q && !fifo_full && !(pop_c && fifo_empty);

  always_comb begin
    poll_cnt_d = poll_cnt_q;
    if (!en) begin
      poll_cnt_d = '0;
    end else if (poll_c) begin
      poll_cnt_d = (POLL_PERIOD > 1) ? PC_W'(1) : '0;
    end else if (poll_cnt_q != '0) begin
      poll_cnt_d = (poll_cnt_q == PC_W'(POLL_PERIOD - 1)) ? '0 : poll_cnt_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin : poll_p
    logic [SB_MAX_DW-1:0] rdata;
    logic [SB_DEST_W-1:0] rdest;
    logic                 rlast;
    int                   success;
    if (!nreset) begin
      stage_q     <= '0;
      stage_vld_q <= 1'b0;
      poll_cnt_q  <= '0;
      pkt_cnt_q   <= '0;
    end else begin
      poll_cnt_q  <= poll_cnt_d;
      stage_vld_q <= 1'b0;
      if (poll_c) begin
        pi_sb_recv(sb_id, rdata, rdest, rlast, success);
        if (success == 1) begin
          stage_q     <= {rdata[DW-1:0], rdest, rlast};
          stage_vld_q <= 1'b1;
          pkt_cnt_q   <= pkt_cnt_q + 32'd1;
        end
      end
    end
  end

  sb_sim_fifo #(
    .W     (PKT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (nreset),
    .push_i      (fifo_push_c),
    .push_data_i (stage_q),
    .pop_i       (fifo_pop_c),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign head_c              = fifo_empty ? stage_q : fifo_head;
  assign {data, dest, last}  = head_c;
  assign count               = occ_c;
  assign pkt_cnt             = pkt_cnt_q;

endmodule

// File: tb/tb_sb_rx_sim_buf.sv
// Directed and randomized checks of sb_rx_sim_buf against a packet-order reference model.
module tb_sb_rx_sim_buf;
  import sb_sim_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         nreset, en_a, en_b, ready_a, ready_b;
  logic [255:0] data_a;
  logic [63:0]  data_b;
  logic [31:0]  dest_a, dest_b, pkt_cnt_a, pkt_cnt_b;
  logic         last_a, last_b, valid_a, valid_b;
  logic [2:0]   count_a, count_b;

  int errors = 0;
  int checks = 0;

  sb_rx_sim_buf #(.DW(256), .DEPTH(4), .POLL_PERIOD(1)) u_a (
    .clk(clk), .nreset(nreset), .en(en_a), .data(data_a), .dest(dest_a), .last(last_a),
    .valid(valid_a), .ready(ready_a), .count(count_a), .pkt_cnt(pkt_cnt_a));

  sb_rx_sim_buf #(.DW(64), .DEPTH(4), .POLL_PERIOD(3)) u_b (
    .clk(clk), .nreset(nreset), .en(en_b), .data(data_b), .dest(dest_b), .last(last_b),
    .valid(valid_b), .ready(ready_b), .count(count_b), .pkt_cnt(pkt_cnt_b));

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input string uri, input logic [255:0] d, input logic [31:0] ds, input logic l);
    sb_pkt_t p;
    p.data = d;
    p.dest = ds;
    p.last = l;
    sb_sim_send(uri, p);
  endtask

  initial begin
    logic [255:0] big;
    logic [255:0] exp_b [3];
    logic [255:0] prev_data;
    logic         prev_valid, prev_pop;
    sb_pkt_t      p;
    sb_pkt_t      exp_q [$];
    int           got, last_inc, sent;
    logic [31:0]  prev_cnt;

    nreset = 1'b0; en_a = 1'b0; en_b = 1'b0; ready_a = 1'b0; ready_b = 1'b0;
    u_a.init("rx_a");
    u_b.init("rx_b");
    repeat (3) step();
    check("rst_valid", 256'(valid_a), 256'(0));
    check("rst_count", 256'(count_a), 256'(0));
    check("rst_pkt_cnt", 256'(pkt_cnt_a), 256'(0));

    // Idle: empty queue, polling enabled
    nreset = 1'b1; en_a = 1'b1; ready_a = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_valid", 256'(valid_a), 256'(0));
    end
    check("idle_pkt_cnt", 256'(pkt_cnt_a), 256'(0));

    // Back-to-back: one packet per cycle, first visible one edge after the first poll
    for (int i = 0; i < 8; i++) send("rx_a", 256'(i), 32'h100 + 32'(i), (i == 7));
    for (int i = 0; i < 8; i++) begin
      step();
      check("b2b_valid", 256'(valid_a), 256'(1));
      check("b2b_data", data_a, 256'(i));
      check("b2b_dest", 256'(dest_a), 256'(32'h100 + 32'(i)));
      check("b2b_last", 256'(last_a), 256'(i == 7));
    end
    step();
    check("b2b_empty", 256'(valid_a), 256'(0));
    check("b2b_pkt_cnt", 256'(pkt_cnt_a), 256'(8));

    // Backpressure: fill to DEPTH, no further polls, then drain in order
    ready_a = 1'b0;
    for (int i = 0; i < 10; i++) send("rx_a", 256'(1000 + i), 32'h200 + 32'(i), 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step();
      check("bp_count", 256'(count_a), 256'((i < 4) ? i : 4));
      check("bp_head", data_a, 256'(1000));
    end
    check("bp_pkt_cnt_full", 256'(pkt_cnt_a), 256'(12));
    ready_a = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 10; c++) begin
      if (valid_a) begin
        check("bp_order", data_a, 256'(1000 + got));
        got++;
      end
      step();
    end
    check("bp_delivered", 256'(got), 256'(10));
    check("bp_pkt_cnt_end", 256'(pkt_cnt_a), 256'(18));
    check("bp_empty", 256'(valid_a), 256'(0));

    // Truncation and throttle on the narrow instance
    big      = {{6{32'hAAAA_AAAA}}, 64'h1234_5678_9ABC_DEF0};
    exp_b[0] = 256'(64'h1234_5678_9ABC_DEF0);
    exp_b[1] = 256'(64'hFEDC_BA98_7654_3210);
    exp_b[2] = 256'(64'h0F0F_0F0F_5555_AAAA);
    send("rx_b", big, 32'h300, 1'b1);
    send("rx_b", {big[255:64], 64'hFEDC_BA98_7654_3210}, 32'h301, 1'b0);
    send("rx_b", {big[255:64], 64'h0F0F_0F0F_5555_AAAA}, 32'h302, 1'b1);
    en_b = 1'b1;
    last_inc = -100;
    prev_cnt = pkt_cnt_b;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (pkt_cnt_b != prev_cnt) begin
        if (last_inc > 0) check("thr_gap", 256'(c - last_inc), 256'(3));
        last_inc = c;
        prev_cnt = pkt_cnt_b;
      end
    end
    check("thr_pkt_cnt", 256'(pkt_cnt_b), 256'(3));
    check("thr_count", 256'(count_b), 256'(3));
    check("trunc_data", 256'(data_b), exp_b[0]);
    check("trunc_dest", 256'(dest_b), 256'(32'h300));
    check("trunc_last", 256'(last_b), 256'(1));
    ready_b = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 3; c++) begin
      if (valid_b) begin
        check("trunc_order", 256'(data_b), exp_b[got]);
        got++;
      end
      step();
    end
    check("trunc_delivered", 256'(got), 256'(3));

    // Enable gating: queued packets stay queued while en is low
    en_a = 1'b0; ready_a = 1'b1;
    send("rx_a", 256'(2000), 32'h400, 1'b0);
    send("rx_a", 256'(2001), 32'h401, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step();
      check("en_gate_valid", 256'(valid_a), 256'(0));
    end
    en_a = 1'b1;
    got = 0;
    for (int c = 0; c < 10 && got < 2; c++) begin
      if (valid_a) begin
        check("en_order", data_a, 256'(2000 + got));
        got++;
      end
      step();
    end
    check("en_delivered", 256'(got), 256'(2));
    check("en_pkt_cnt", 256'(pkt_cnt_a), 256'(20));

    // Reset mid-operation with 3 buffered entries
    ready_a = 1'b0;
    for (int i = 0; i < 5; i++) send("rx_a", 256'(3000 + i), 32'h500 + 32'(i), 1'b0);
    repeat (3) step();
    check("rmid_count_pre", 256'(count_a), 256'(3));
    #2 nreset = 1'b0;
    #1;
    check("rmid_valid", 256'(valid_a), 256'(0));
    check("rmid_count", 256'(count_a), 256'(0));
    check("rmid_pkt_cnt", 256'(pkt_cnt_a), 256'(0));
    #2 nreset = 1'b1;
    ready_a = 1'b1;
    step();
    got = 0;
    for (int c = 0; c < 20 && got < 2; c++) begin
      if (valid_a) begin
        check("rmid_order", data_a, 256'(3003 + got));
        got++;
      end
      step();
    end
    check("rmid_delivered", 256'(got), 256'(2));
    check("rmid_pkt_cnt_end", 256'(pkt_cnt_a), 256'(2));

    // Randomized traffic, enable and backpressure against an in-order packet model
    sent = 0;
    prev_valid = 1'b0;
    prev_pop = 1'b0;
    prev_data = '0;
    for (int c = 0; c < 400; c++) begin
      if (prev_valid && !prev_pop) begin
        check("rnd_hold_valid", 256'(valid_a), 256'(1));
        check("rnd_hold_data", data_a, prev_data);
      end
      check("rnd_count_max", 256'(count_a <= 3'd4), 256'(1));
      if (sent < 60 && $urandom_range(0, 2) == 0) begin
        for (int k = 0; k < 8; k++) p.data[k*32 +: 32] = $urandom();
        p.dest = $urandom();
        p.last = 1'($urandom_range(0, 1));
        sb_sim_send("rx_a", p);
        exp_q.push_back(p);
        sent++;
      end
      en_a    = ($urandom_range(0, 3) != 0);
      ready_a = 1'($urandom_range(0, 1));
      prev_pop = valid_a && ready_a;
      if (prev_pop) begin
        check("rnd_model_nonempty", 256'(exp_q.size() > 0), 256'(1));
        if (exp_q.size() > 0) begin
          check("rnd_data", data_a, exp_q[0].data);
          check("rnd_dest", 256'(dest_a), 256'(exp_q[0].dest));
          check("rnd_last", 256'(last_a), 256'(exp_q[0].last));
          void'(exp_q.pop_front());
        end
      end
      prev_valid = valid_a;
      prev_data  = data_a;
      step();
    end
    en_a = 1'b1; ready_a = 1'b1;
    for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
      if (valid_a) begin
        check("rnd_drain_data", data_a, exp_q[0].data);
        void'(exp_q.pop_front());
      end
      step();
    end
    check("rnd_drained", 256'(exp_q.size()), 256'(0));
    check("rnd_pkt_cnt", 256'(pkt_cnt_a), 256'(2 + sent));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
